// File: rtl/b04_sample_feeder_pkg.sv
// Shared tag codes, state encoding and FIFO entry layout for the b04 sample feeder.
package b04_feeder_pkg;

    localparam logic [1:0] TAG_DATA    = 2'b00;
    localparam logic [1:0] TAG_AVG     = 2'b01;
    localparam logic [1:0] TAG_RESTART = 2'b10;
    localparam logic [1:0] TAG_GAP     = 2'b11;

    localparam int ENTRY_W = 10;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [1:0] tag;
        logic [7:0] data;
    } entry_t;

endpackage

// File: rtl/b04_sample_feeder_if.sv
// Producer-side valid/ready channel carrying tagged signed samples into the feeder.
interface b04_sample_feeder_if;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] IN_DATA;
    logic [1:0] IN_TAG;

    modport master (output IN_VALID, output IN_DATA, output IN_TAG, input IN_READY);
    modport slave  (input IN_VALID, input IN_DATA, input IN_TAG, output IN_READY);
endinterface

// File: rtl/b04_sample_feeder_fifo.sv
// Synchronous FIFO with a combinational head read, so a popped entry decodes on the same edge.
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/b04_sample_feeder.sv
// Buffers tagged samples and replays them to the b04 processor as one registered event
// per cycle, with a warm-up phase after reset and optional idle gaps after data samples.
module b04_sample_feeder
    import b04_feeder_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int GAP    = 0,
    parameter int WARMUP = 2
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    b04_sample_feeder_if.slave   in_if,
    output logic [7:0]           DATA_IN,
    output logic                 ENABLE,
    output logic                 AVERAGE,
    output logic                 RESTART,
    output logic                 BUSY,
    output logic [7:0]           SAMPLE_CNT
);
    localparam int CW = $clog2(DEPTH);

    state_t          state_q, state_d;
    logic [15:0]     warm_q, warm_d;
    logic [3:0]      gap_q, gap_d;
    logic [7:0]      data_q, data_d;
    logic            en_q, en_d;
    logic            avg_q, avg_d;
    logic            rs_q, rs_d;
    logic [7:0]      cnt_q, cnt_d;

    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW:0]     fifo_count;
    logic [ENTRY_W-1:0] fifo_rd;
    entry_t          head;
    logic            in_ready;

    assign in_ready       = RESET && !fifo_full;
    assign in_if.IN_READY = in_ready;
    // Gap-filler entries complete the handshake but are never stored.
    assign fifo_push = in_if.IN_VALID && in_ready && (in_if.IN_TAG != TAG_GAP);
    assign fifo_pop  = (state_q == RUN) && !fifo_empty && (gap_q == 4'd0);
    assign head      = entry_t'(fifo_rd);

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (CLOCK),
        .rst_n   (RESET),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data ({in_if.IN_TAG, in_if.IN_DATA}),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q <= WARM;
            warm_q  <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            avg_q   <= 1'b0;
            rs_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            en_q    <= en_d;
            avg_q   <= avg_d;
            rs_q    <= rs_d;
            cnt_q   <= cnt_d;
        end
    end

    // Warm-up hides the downstream two-cycle startup before the first pop.
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        if (state_q == WARM) begin
            warm_d = warm_q + 16'd1;
            if ((warm_q + 16'd1) >= 16'(WARMUP)) state_d = RUN;
        end
    end

    // Strobes default low every cycle because downstream updates on each edge.
    always_comb begin
        data_d = data_q;
        en_d   = 1'b0;
        avg_d  = 1'b0;
        rs_d   = 1'b0;
        cnt_d  = cnt_q;
        gap_d  = (gap_q != 4'd0) ? gap_q - 4'd1 : 4'd0;
        if (fifo_pop) begin
            data_d = head.data;
            if (head.tag == TAG_RESTART) begin
                rs_d = 1'b1;
            end else begin
                en_d  = 1'b1;
                avg_d = (head.tag == TAG_AVG);
                cnt_d = cnt_q + 8'd1;
                gap_d = 4'(GAP);
            end
        end
    end

    assign DATA_IN    = data_q;
    assign ENABLE     = en_q;
    assign AVERAGE    = avg_q;
    assign RESTART    = rs_q;
    assign SAMPLE_CNT = cnt_q;
    assign BUSY       = (state_q != RUN) || (fifo_count != '0) || (gap_q != 4'd0);

endmodule

// File: tb/tb_b04_sample_feeder.sv
// Self-checking bench for b04_sample_feeder: directed table, corner sequences and random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_b04_sample_feeder;
    localparam int DEPTH  = 4;
    localparam int GAP    = 3;
    localparam int WARMUP = 2;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic [7:0] DATA_IN;
    logic       ENABLE, AVERAGE, RESTART, BUSY;
    logic [7:0] SAMPLE_CNT;

    b04_sample_feeder_if fif ();

    b04_sample_feeder #(
        .DEPTH  (DEPTH),
        .GAP    (GAP),
        .WARMUP (WARMUP)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .in_if      (fif.slave),
        .DATA_IN    (DATA_IN),
        .ENABLE     (ENABLE),
        .AVERAGE    (AVERAGE),
        .RESTART    (RESTART),
        .BUSY       (BUSY),
        .SAMPLE_CNT (SAMPLE_CNT)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of pending {tag,data}, warm-up progress, gap and output values.
    logic [9:0] m_q [$];
    int         m_warm;
    bit         m_run;
    int         m_gap;
    logic [7:0] m_data, m_cnt;
    logic       m_en, m_avg, m_rs;
    bit         ready_seen_low;

    typedef struct {
        logic       v;
        logic [1:0] tag;
        logic [7:0] data;
        logic       e_en, e_avg, e_rs;
        logic [7:0] e_data, e_cnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic v, input logic [1:0] tag, input logic [7:0] data);
        bit         acc, pop;
        logic [9:0] e;
        if (!rst) begin
            m_q.delete();
            m_warm = 0; m_run = 0; m_gap = 0;
            m_data = 0; m_en = 0; m_avg = 0; m_rs = 0; m_cnt = 0;
        end else begin
            acc = v && (m_q.size() < DEPTH) && (tag != 2'b11);
            pop = m_run && (m_q.size() > 0) && (m_gap == 0);
            m_en = 0; m_avg = 0; m_rs = 0;
            if (m_gap > 0) m_gap--;
            if (pop) begin
                e = m_q.pop_front();
                m_data = e[7:0];
                if (e[9:8] == 2'b10) begin
                    m_rs = 1;
                end else begin
                    m_en  = 1;
                    m_avg = (e[9:8] == 2'b01);
                    m_cnt = m_cnt + 8'd1;
                    m_gap = GAP;
                end
                $display("issue t=%0t tag=%0d data=%02h cnt=%0d", $time, e[9:8], e[7:0], m_cnt);
            end
            if (acc) m_q.push_back({tag, data});
            if (!m_run) begin
                m_warm++;
                if (m_warm >= WARMUP) m_run = 1;
            end
        end
    endtask

    // One clock: drive inputs, check IN_READY, clock, advance model, check registered outputs.
    task automatic cycle(input logic rst, input logic v, input logic [1:0] tag, input logic [7:0] data);
        RESET        = rst;
        fif.IN_VALID = v;
        fif.IN_TAG   = tag;
        fif.IN_DATA  = data;
        #1;
        check("in_ready", fif.IN_READY, rst && (m_q.size() < DEPTH));
        if (rst && v && !fif.IN_READY) ready_seen_low = 1;
        @(posedge CLOCK);
        model_edge(rst, v, tag, data);
        @(negedge CLOCK);
        check("data_in", DATA_IN, m_data);
        check("enable", ENABLE, m_en);
        check("average", AVERAGE, m_avg);
        check("restart", RESTART, m_rs);
        check("busy", BUSY, !m_run || (m_q.size() > 0) || (m_gap != 0));
        check("sample_cnt", SAMPLE_CNT, m_cnt);
        check("en_rs_exclusive", ENABLE && RESTART, 1'b0);
    endtask

    initial begin
        vec_t       tbl [12];
        logic [7:0] got [$];
        int         idx, last, spacing_bad, n_ev;
        bit         acc;

        RESET = 0; fif.IN_VALID = 0; fif.IN_TAG = 0; fif.IN_DATA = 0;
        ready_seen_low = 0;
        @(negedge CLOCK);

        // Reset for two cycles, then the warm-up window.
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("warm_busy_1", BUSY, 1'b1);
        cycle(1, 0, 0, 0);
        check("run_busy_0", BUSY, 1'b0);

        // Directed table with hand-derived expectations (GAP=3).
        tbl[0]  = '{1, 2'b00, 8'h05, 0, 0, 0, 8'h00, 8'd0};
        tbl[1]  = '{0, 2'b00, 8'h00, 1, 0, 0, 8'h05, 8'd1};
        tbl[2]  = '{0, 2'b00, 8'h00, 0, 0, 0, 8'h05, 8'd1};
        tbl[3]  = '{1, 2'b01, 8'hFD, 0, 0, 0, 8'h05, 8'd1};
        tbl[4]  = '{1, 2'b10, 8'h10, 0, 0, 0, 8'h05, 8'd1};
        tbl[5]  = '{1, 2'b11, 8'h7F, 1, 1, 0, 8'hFD, 8'd2};
        tbl[6]  = '{0, 2'b00, 8'h00, 0, 0, 0, 8'hFD, 8'd2};
        tbl[7]  = '{0, 2'b00, 8'h00, 0, 0, 0, 8'hFD, 8'd2};
        tbl[8]  = '{0, 2'b00, 8'h00, 0, 0, 0, 8'hFD, 8'd2};
        tbl[9]  = '{0, 2'b00, 8'h00, 0, 0, 1, 8'h10, 8'd2};
        tbl[10] = '{0, 2'b00, 8'h00, 0, 0, 0, 8'h10, 8'd2};
        tbl[11] = '{0, 2'b00, 8'h00, 0, 0, 0, 8'h10, 8'd2};
        for (int i = 0; i < 12; i++) begin
            cycle(1, tbl[i].v, tbl[i].tag, tbl[i].data);
            check($sformatf("tbl%0d_en", i), ENABLE, tbl[i].e_en);
            check($sformatf("tbl%0d_avg", i), AVERAGE, tbl[i].e_avg);
            check($sformatf("tbl%0d_rs", i), RESTART, tbl[i].e_rs);
            check($sformatf("tbl%0d_data", i), DATA_IN, tbl[i].e_data);
            check($sformatf("tbl%0d_cnt", i), SAMPLE_CNT, tbl[i].e_cnt);
        end

        // Six back-to-back samples: back-pressure, ordering and GAP+1 spacing.
        idx = 0; last = -1; spacing_bad = 0; ready_seen_low = 0;
        for (int c = 0; c < 60; c++) begin
            acc = (idx < 6) && (m_q.size() < DEPTH);
            cycle(1, idx < 6, 2'b00, 8'h20 + 8'(idx));
            if (acc) idx++;
            if (ENABLE) begin
                got.push_back(DATA_IN);
                if (last >= 0 && (c - last) != GAP + 1) spacing_bad++;
                last = c;
            end
        end
        check("burst_count", got.size(), 6);
        for (int i = 0; i < got.size(); i++) check($sformatf("burst_order%0d", i), got[i], 8'h20 + 8'(i));
        check("burst_spacing_bad", spacing_bad, 0);
        check("burst_ready_dropped", ready_seen_low, 1'b1);

        // 256 data samples after a fresh reset: counter wraps back to zero.
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        idx = 0; n_ev = 0;
        for (int c = 0; c < 1100; c++) begin
            acc = (idx < 256) && (m_q.size() < DEPTH);
            cycle(1, idx < 256, 2'b00, 8'($urandom));
            if (acc) idx++;
            if (ENABLE) n_ev++;
        end
        check("wrap_strobes", n_ev, 256);
        check("wrap_cnt", SAMPLE_CNT, 8'd0);

        // Reset with three entries queued: none of them may ever issue.
        cycle(1, 1, 2'b00, 8'hAA);
        cycle(1, 1, 2'b00, 8'hAB);
        cycle(1, 1, 2'b00, 8'hAC);
        cycle(1, 1, 2'b00, 8'hAD);
        check("queued_busy", BUSY, 1'b1);
        cycle(0, 0, 0, 0);
        check("rst_enable", ENABLE, 1'b0);
        check("rst_data", DATA_IN, 8'h00);
        n_ev = 0;
        for (int c = 0; c < 20; c++) begin
            cycle(1, 0, 0, 0);
            if (c == 0) check("rewarm_busy", BUSY, 1'b1);
            if (ENABLE || RESTART) n_ev++;
        end
        check("flushed_never_issued", n_ev, 0);

        // Random traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            cycle($urandom_range(0, 99) != 0, $urandom_range(0, 1), 2'($urandom), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
